// File: rtl/gate_pair_checker_pkg.sv
// Purpose: shared types and constants for the gate-pair stimulus/response checker.
// Latency: none (declarations only).
// Backpressure: none.
package gate_pair_checker_pkg;

    // Checker sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int         ERR_W   = 8;
    localparam logic [7:0] ERR_MAX = 8'd255;

    // Settle counter width; holds SETTLE values up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/gpc_pattern_gen.sv
// Purpose: pattern index register and settle-wait counter for the gate-pair checker.
// Latency: index and counter update one cycle after clear/step/load.
// Backpressure: none; the controlling FSM decides when to step or load.
module gpc_pattern_gen
    import gate_pair_checker_pkg::*;
#(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    input  logic           load,
    output logic [2*W-1:0] idx,
    output logic           last,
    output logic           settled
);

    localparam logic [2*W-1:0]   IDX_ONE    = 1;
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;

    logic [CNT_W-1:0] wait_cnt;

    // Pattern index: cleared at run start, advanced after each non-final check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + IDX_ONE;
        end
    end

    // Settle counter: loaded on drive, counts down and parks at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= SETTLE_VAL;
        end else if (wait_cnt > CNT_ONE) begin
            wait_cnt <= wait_cnt - CNT_ONE;
        end
    end

    assign last    = &idx;
    assign settled = (wait_cnt == CNT_ONE);

endmodule

// File: rtl/gate_pair_checker.sv
// Purpose: drives every a/b pattern into an AND/OR gate pair and checks the results.
// Latency: (SETTLE+2) cycles per pattern; done 2^(2W)*(SETTLE+2)+1 cycles after start.
// Backpressure: none; start is ignored while busy. Optional GPC_FAIL_STOP_EN stops at the first mismatch.
module gate_pair_checker
    import gate_pair_checker_pkg::*;
#(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     and_i,
    input  logic [W-1:0]     or_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2*W-1:0]   first_fail_idx
);

    localparam logic [ERR_W-1:0] ERR_ONE = 1;

    state_t         state;
    state_t         state_nxt;
    logic [2*W-1:0] idx;
    logic           last;
    logic           settled;
    logic           clear;
    logic           step;
    logic           load;
    logic           chk_en;
    logic           mismatch;

    gpc_pattern_gen #(
        .W      (W),
        .SETTLE (SETTLE)
    ) u_pattern_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .step    (step),
        .load    (load),
        .idx     (idx),
        .last    (last),
        .settled (settled)
    );

    // Compare the returned gate outputs against the currently driven operands
    assign mismatch = (and_i != (a_o & b_o)) || (or_i != (a_o | b_o));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = WAIT;
            WAIT:    if (settled) state_nxt = CHECK;
`ifdef GPC_FAIL_STOP_EN
            CHECK:   state_nxt = (last || mismatch) ? FINISH : DRIVE;
`else
            CHECK:   state_nxt = last ? FINISH : DRIVE;
`endif
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        clear  = (state == IDLE) && start;
        load   = (state == DRIVE);
        chk_en = (state == CHECK);
        step   = (state == CHECK) && (state_nxt == DRIVE);
        busy   = (state != IDLE);
    end

    // Operand registers: updated on drive, held otherwise (including idle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o <= '0;
            b_o <= '0;
        end else if (load) begin
            a_o <= idx[W-1:0];
            b_o <= idx[2*W-1:W];
        end
    end

    // Error counter with saturation, and first failing index capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            first_fail_idx <= '0;
        end else if (clear) begin
            err_count      <= '0;
            first_fail_idx <= '0;
        end else if (chk_en && mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_ONE;
            end
            if (err_count == '0) begin
                first_fail_idx <= idx;
            end
        end
    end

    // Completion pulse and sticky pass flag, both produced out of FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (clear) begin
                pass <= 1'b0;
            end else if (state == FINISH) begin
                pass <= (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_gate_pair_checker.sv
module tb_gate_pair_checker;

`ifdef GPC_FAIL_STOP_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    localparam int S2 = 1;
    localparam int S4 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start2 = 1'b0;
    logic [1:0] and2, or2, a2, b2;
    logic       busy2, done2, pass2;
    logic [7:0] err2;
    logic [3:0] ffi2;

    logic       start4 = 1'b0;
    logic [3:0] and4, or4, a4, b4;
    logic       busy4, done4, pass4;
    logic [7:0] err4;
    logic [7:0] ffi4;

    logic [1:0] ax2 [16];
    logic [1:0] ox2 [16];
    logic [3:0] ax4 [256];
    logic [3:0] ox4 [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gate_pair_checker #(.W(2), .SETTLE(S2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .and_i(and2), .or_i(or2),
        .a_o(a2), .b_o(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_idx(ffi2)
    );

    gate_pair_checker #(.W(4), .SETTLE(S4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .and_i(and4), .or_i(or4),
        .a_o(a4), .b_o(b4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail_idx(ffi4)
    );

    // Gate pair under test: ideal gates with a per-pattern fault XOR mask
    always_comb begin
        and2 = (a2 & b2) ^ ax2[{b2, a2}];
        or2  = (a2 | b2) ^ ox2[{b2, a2}];
        and4 = (a4 & b4) ^ ax4[{b4, a4}];
        or4  = (a4 | b4) ^ ox4[{b4, a4}];
    end

    // mode: 0 ideal, 1 and[0] stuck-at-0, 2 and inverted, 3 sparse random faults
    task automatic set_masks(input int which, input int mode);
        logic [3:0] av, bv;
        int n;
        n = (which == 2) ? 16 : 256;
        for (int p = 0; p < n; p++) begin
            if (which == 2) begin
                av = 4'(p & 3);
                bv = 4'((p >> 2) & 3);
            end else begin
                av = 4'(p & 15);
                bv = 4'((p >> 4) & 15);
            end
            if (which == 2) begin
                case (mode)
                    1: begin ax2[p] = 2'((av & bv) & 4'd1); ox2[p] = 2'd0; end
                    2: begin ax2[p] = 2'd3; ox2[p] = 2'd0; end
                    3: begin
                        ax2[p] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
                        ox2[p] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
                    end
                    default: begin ax2[p] = 2'd0; ox2[p] = 2'd0; end
                endcase
            end else begin
                case (mode)
                    1: begin ax4[p] = (av & bv) & 4'd1; ox4[p] = 4'd0; end
                    2: begin ax4[p] = 4'hF; ox4[p] = 4'd0; end
                    3: begin
                        ax4[p] = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'd0;
                        ox4[p] = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'd0;
                    end
                    default: begin ax4[p] = 4'd0; ox4[p] = 4'd0; end
                endcase
            end
        end
    endtask

    // Reference: walk the patterns, count faulty ones, derive status and run length
    task automatic model(input int which, output int e_err, output int e_first,
                         output int e_pass, output int e_cyc);
        int n, s, ran;
        bit mm, stop;
        n = (which == 2) ? 16 : 256;
        s = (which == 2) ? S2 : S4;
        ran = 0; e_err = 0; e_first = 0; stop = 0;
        for (int p = 0; p < n; p++) begin
            if (!stop) begin
                ran++;
                if (which == 2) mm = (ax2[p] != 0) || (ox2[p] != 0);
                else            mm = (ax4[p] != 0) || (ox4[p] != 0);
                if (mm) begin
                    if (e_err == 0) e_first = p;
                    if (e_err < 255) e_err++;
                    if (FS) stop = 1;
                end
            end
        end
        e_pass = (e_err == 0) ? 1 : 0;
        e_cyc  = ran * (s + 2) + 1;
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 2) start2 = v;
        else            start4 = v;
    endtask

    function automatic logic get_done(input int which);
        return (which == 2) ? done2 : done4;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 2) ? busy2 : busy4;
    endfunction

    function automatic int get_pat(input int which);
        return (which == 2) ? int'({b2, a2}) : int'({b4, a4});
    endfunction

    // Start a run (unless start is already held) and count cycles to done
    task automatic run(input int which, input bit pre_started, input int pulse_at,
                       input int hold_at, output int cyc, output bit seq_ok,
                       output bit rise_ok);
        int cur, prev;
        bit dn;
        if (!pre_started) begin
            @(posedge clk); #1;
            drive_start(which, 1'b1);
        end
        @(posedge clk); #1;
        drive_start(which, 1'b0);
        rise_ok = get_busy(which);
        cyc = 0; prev = -1; seq_ok = 1; dn = 0;
        while (!dn && cyc < 3000) begin
            if (cyc == pulse_at) drive_start(which, 1'b1);
            else if (cyc == pulse_at + 1) drive_start(which, 1'b0);
            if (cyc == hold_at) drive_start(which, 1'b1);
            @(posedge clk); #1;
            cyc++;
            cur = get_pat(which);
            if (cur != prev && cur != prev + 1) seq_ok = 0;
            prev = cur;
            dn = get_done(which);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start2 = 1'b1; start4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if ({a2, b2} !== 4'd0) begin n_fail++; $display("FAIL reset_ab2 got=%0h exp=0", {a2, b2}); end
        n_tests++; if ({busy2, done2, pass2} !== 3'd0) begin n_fail++; $display("FAIL reset_flags2 got=%b exp=000", {busy2, done2, pass2}); end
        n_tests++; if (err2 !== 8'd0) begin n_fail++; $display("FAIL reset_err2 got=%0d exp=0", err2); end
        n_tests++; if (ffi2 !== 4'd0) begin n_fail++; $display("FAIL reset_ffi2 got=%0d exp=0", ffi2); end
        n_tests++; if ({a4, b4, busy4, done4, pass4, err4, ffi4} !== 27'd0) begin n_fail++; $display("FAIL reset_all4 got=%0h exp=0", {a4, b4, busy4, done4, pass4, err4, ffi4}); end
        start2 = 1'b0; start4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if ({busy2, busy4} !== 2'b00) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=00", {busy2, busy4}); end
    endtask

    task automatic test_ideal;
        int cyc; bit sq, rs;
        set_masks(2, 0);
        run(2, 0, -5, -5, cyc, sq, rs);
        n_tests++; if (rs !== 1'b1) begin n_fail++; $display("FAIL ideal_busy_rise got=%b exp=1", rs); end
        n_tests++; if (cyc !== 49) begin n_fail++; $display("FAIL ideal_done_cycle got=%0d exp=49", cyc); end
        n_tests++; if ({pass2, busy2} !== 2'b10) begin n_fail++; $display("FAIL ideal_pass_busy got=%b exp=10", {pass2, busy2}); end
        n_tests++; if (err2 !== 8'd0 || ffi2 !== 4'd0) begin n_fail++; $display("FAIL ideal_err_ffi got=%0d/%0d exp=0/0", err2, ffi2); end
        n_tests++; if (sq !== 1'b1 || {b2, a2} !== 4'd15) begin n_fail++; $display("FAIL ideal_sequence got=%b/%0d exp=1/15", sq, {b2, a2}); end
        @(posedge clk); #1;
        n_tests++; if (done2 !== 1'b0 || pass2 !== 1'b1) begin n_fail++; $display("FAIL ideal_done_pulse got=%b%b exp=01", done2, pass2); end
    endtask

    task automatic test_stuck_and0;
        int cyc; bit sq, rs;
        set_masks(2, 1);
        run(2, 0, -5, -5, cyc, sq, rs);
        n_tests++; if (cyc !== (FS ? 19 : 49)) begin n_fail++; $display("FAIL stuck_done_cycle got=%0d exp=%0d", cyc, FS ? 19 : 49); end
        n_tests++; if (err2 !== (FS ? 8'd1 : 8'd4)) begin n_fail++; $display("FAIL stuck_err got=%0d exp=%0d", err2, FS ? 1 : 4); end
        n_tests++; if (ffi2 !== 4'd5) begin n_fail++; $display("FAIL stuck_ffi got=%0d exp=5", ffi2); end
        n_tests++; if (pass2 !== 1'b0) begin n_fail++; $display("FAIL stuck_pass got=%b exp=0", pass2); end
    endtask

    task automatic test_saturation;
        int cyc; bit sq, rs;
        set_masks(4, 2);
        run(4, 0, -5, -5, cyc, sq, rs);
        n_tests++; if (cyc !== (FS ? 6 : 1281)) begin n_fail++; $display("FAIL sat_done_cycle got=%0d exp=%0d", cyc, FS ? 6 : 1281); end
        n_tests++; if (err4 !== (FS ? 8'd1 : 8'd255)) begin n_fail++; $display("FAIL sat_err got=%0d exp=%0d", err4, FS ? 1 : 255); end
        n_tests++; if ({pass4, ffi4} !== 9'd0) begin n_fail++; $display("FAIL sat_pass_ffi got=%b/%0d exp=0/0", pass4, ffi4); end
    endtask

    task automatic test_reset_mid_run;
        int cyc, guard; bit sq, rs;
        set_masks(2, 0);
        @(posedge clk); #1; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        guard = 0;
        while ({b2, a2} != 4'd7 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_tests++; if ({b2, a2, busy2} !== 5'b01111) begin n_fail++; $display("FAIL midrst_reach7 got=%0d busy=%b exp=7 busy=1", {b2, a2}, busy2); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({a2, b2, busy2, done2, pass2, err2, ffi2} !== 19'd0) begin n_fail++; $display("FAIL midrst_outputs got=%0h exp=0", {a2, b2, busy2, done2, pass2, err2, ffi2}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // a start pulse mid-run must not disturb the run length
        run(2, 0, 20, -5, cyc, sq, rs);
        n_tests++; if (cyc !== 49) begin n_fail++; $display("FAIL midrst_rerun_cycle got=%0d exp=49", cyc); end
        n_tests++; if ({pass2, err2} !== 9'h100 || sq !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_status got=%b/%0d seq=%b exp=1/0 seq=1", pass2, err2, sq); end
    endtask

    task automatic test_back_to_back;
        int cyc; bit sq, rs;
        set_masks(2, 0);
        // start raised during FINISH and held into the following idle cycle
        run(2, 0, -5, 48, cyc, sq, rs);
        n_tests++; if (cyc !== 49) begin n_fail++; $display("FAIL b2b_first_cycle got=%0d exp=49", cyc); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_finish_ignored got=busy%b exp=busy0", busy2); end
        run(2, 1, -5, -5, cyc, sq, rs);
        n_tests++; if (rs !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", rs); end
        n_tests++; if (cyc !== 49 || pass2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_run got=%0d/%b exp=49/1", cyc, pass2); end
    endtask

    task automatic test_random;
        int cyc, e_err, e_first, e_pass, e_cyc; bit sq, rs;
        for (int it = 0; it < 6; it++) begin
            set_masks(2, 3);
            model(2, e_err, e_first, e_pass, e_cyc);
            run(2, 0, -5, -5, cyc, sq, rs);
            n_tests++; if (cyc !== e_cyc) begin n_fail++; $display("FAIL rand2_cycle it=%0d got=%0d exp=%0d", it, cyc, e_cyc); end
            n_tests++; if (int'(err2) !== e_err) begin n_fail++; $display("FAIL rand2_err it=%0d got=%0d exp=%0d", it, err2, e_err); end
            n_tests++; if (int'(ffi2) !== e_first || int'(pass2) !== e_pass) begin n_fail++; $display("FAIL rand2_ffi_pass it=%0d got=%0d/%b exp=%0d/%0d", it, ffi2, pass2, e_first, e_pass); end
        end
        set_masks(4, 3);
        model(4, e_err, e_first, e_pass, e_cyc);
        run(4, 0, -5, -5, cyc, sq, rs);
        n_tests++; if (cyc !== e_cyc || sq !== 1'b1) begin n_fail++; $display("FAIL rand4_cycle got=%0d seq=%b exp=%0d seq=1", cyc, sq, e_cyc); end
        n_tests++; if (int'(err4) !== e_err || int'(ffi4) !== e_first || int'(pass4) !== e_pass) begin n_fail++; $display("FAIL rand4_status got=%0d/%0d/%b exp=%0d/%0d/%0d", err4, ffi4, pass4, e_err, e_first, e_pass); end
    endtask

    initial begin
        set_masks(2, 0);
        set_masks(4, 0);
        test_reset();
        test_ideal();
        test_stuck_and0();
        test_saturation();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_pair_checker.md
# gate_pair_checker

Sequential stimulus and response checker for a combinational two-gate cell pair: one AND and one OR, each W bits wide, sharing inputs a and b. It sits at the opposite end of the gate pair's interface. It drives the a/b inputs through every pattern, waits a programmable settle time, samples the AND/OR results and compares them against the expected values. It reports an error count, the first failing pattern index and a pass/done status, and serves as a sequential benchmark and self-checking harness for gate-level netlists.

## Interface
Parameters:
- `W`, default 2: operand width in bits; legal range 1..4.
- `SETTLE`, default 1: wait cycles between driving a pattern and sampling it; legal range 1..15.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a run; honoured only in IDLE.
- `and_i`  in  W  AND result returned by the device under test.
- `or_i`  in  W  OR result returned by the device under test.
- `a_o`  out  W  operand a driven to the device under test.
- `b_o`  out  W  operand b driven to the device under test.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last run had zero errors; held until the next start.
- `err_count`  out  8  mismatch count; saturates at 255.
- `first_fail_idx`  out  2W  index of the first mismatching pattern; 0 when there is none.

## Operation
- Pattern index `idx` is 2W bits and covers 0..2^(2W)-1.
  - `a_o = idx[W-1:0]`.
  - `b_o = idx[2W-1:W]`.
- FSM states:
  - **IDLE**: on `start`, clear `idx`, `err_count`, `first_fail_idx` and `pass`, then go to DRIVE.
  - **DRIVE**: register `a_o`/`b_o` from `idx`, load the wait counter with SETTLE, then go to WAIT.
  - **WAIT**: decrement the wait counter; go to CHECK when it reaches 1.
  - **CHECK**: a mismatch is `and_i != (a_o & b_o)` or `or_i != (a_o | b_o)`. On a mismatch:
    - increment `err_count`, saturating at 255;
    - if `err_count` was 0, capture `idx` into `first_fail_idx`.
    - Then, if `idx` is the last pattern, go to FINISH; otherwise increment `idx` and go to DRIVE.
  - **FINISH**: pulse `done`, set `pass = (err_count == 0)`, then go to IDLE.
- `start` is ignored outside IDLE.
- `a_o`/`b_o` hold their last values in IDLE.
- `idx` does not wrap mid-run; the last pattern always exits to FINISH.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset takes effect immediately, at any point in a run, and discards the run.
- Each pattern costs SETTLE+2 cycles.
- `done` rises exactly 2^(2W)·(SETTLE+2)+1 cycles after the edge that samples `start`.
- `busy` rises on the cycle after `start` is sampled and falls together with `done`.
- A `start` held high during FINISH is ignored. If `start` is high in the following IDLE cycle, it is accepted and `busy` is high again one cycle later.
- `and_i`/`or_i` are sampled only in CHECK; their values in other states do not matter.

## Configuration
- Macro: `GPC_FAIL_STOP_EN`.
- Defined: the first mismatch in CHECK goes straight to FINISH, with `err_count` = 1 and `pass` = 0.
- Undefined: every pattern is run regardless of mismatches.

## Structure
- Package `gate_pair_checker_pkg` holds:
  - the state enum (IDLE, DRIVE, WAIT, CHECK, FINISH);
  - `ERR_W = 8`;
  - `ERR_MAX = 255`.
- One sub-module, `gpc_pattern_gen`:
  - contains the `idx` register and the settle counter;
  - its ports are clear, step and load;
  - it outputs `last` and `settled`.
- The FSM, compare logic and status registers stay in the top module.

## Test plan
- **Reset**: hold `rst_n` low for 3 cycles with `start` = 1. All outputs must be 0; release reset and confirm `busy` stays 0 until `start` is sampled in IDLE.
- **Ideal model** (W=2, SETTLE=1): pulse `start`. `done` must rise at +49 cycles with `pass` = 1, `err_count` = 0 and `first_fail_idx` = 0.
- **Stuck-at-0 on `and_i[0]`** (W=2, SETTLE=1): `err_count` = 4 (indices 5, 7, 13, 15), `first_fail_idx` = 5, `pass` = 0.
- **Saturation** (W=4, `and_i` inverted): all 256 patterns mismatch, so `err_count` = 255 and `first_fail_idx` = 0. Because `pass` = 0, the 0 must be read as the captured index, not as "no failure".
- **Reset and start handling**:
  - Assert `rst_n` low while `idx` = 7. All outputs must return to 0 immediately.
  - A new `start` must then give a clean run that completes 49 cycles later.
  - A `start` pulse while `busy` = 1 must have no effect.
- **`GPC_FAIL_STOP_EN`** (W=2, SETTLE=1, `and_i[0]` stuck-at-0): `done` must rise at +19 cycles with `err_count` = 1, `first_fail_idx` = 5 and `pass` = 0.
